// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter state encoding
// and the default bit period for a 27 MHz clock at 115200 baud.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEFAULT_DELAY_FRAMES = 234;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // True when the received parity bit disagrees with the data's parity
  function automatic logic parity_mismatch(input logic data_xor, input logic rx_bit,
                                           input int mode);
    return rx_bit ^ data_xor ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous pin inputs; resets to the idle-high level.
module uart_sync2 (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting, false-start rejection,
// parity/frame error flags and a valid/ready output register with overrun detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int IW = 4;
  localparam logic [CW-1:0] HALF_M1 = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [CW-1:0] HALF    = CW'(DELAY_FRAMES / 2);
  localparam logic [CW-1:0] HALF_P1 = CW'(DELAY_FRAMES / 2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic                 rx_s;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [1:0]           vote;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc;
  logic                 ferr_acc;

  logic decide;
  logic bit_val;
  logic accept;
  logic commit;
  logic frame_bad;

  uart_sync2 u_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d        (rx_i),
    .q        (rx_s)
  );

  assign decide    = (state != ST_IDLE) && (cnt == HALF_P1);
  assign bit_val   = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
  assign accept    = valid_o && ready_i;
  assign commit    = decide && (state == ST_STOP) && (idx == IW'(STOP_BITS - 1));
  assign frame_bad = ferr_acc | ~bit_val;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      vote         <= 2'b11;
      shreg        <= '0;
      perr_acc     <= 1'b0;
      ferr_acc     <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        if (cnt == HALF_M1) vote[0] <= rx_s;
        if (cnt == HALF)    vote[1] <= rx_s;
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end

      if (accept) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // The cycle that first sees the low line counts as bit phase 0
          if (!rx_s) begin
            state    <= ST_START;
            cnt      <= ONE;
            idx      <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (cnt == LAST) begin
            if (idx == IW'(DATA_BITS - 1)) begin
              idx   <= '0;
              state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) perr_acc <= parity_mismatch(^shreg, bit_val, PARITY);
          if (cnt == LAST) state <= ST_STOP;
        end
        ST_STOP: begin
          // Commit at the last stop-bit decision so a back-to-back start bit is caught
          if (commit) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (!valid_o || ready_i) begin
              data_o       <= shreg;
              parity_err_o <= perr_acc;
              frame_err_o  <= frame_bad;
              valid_o      <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else if (decide) begin
            ferr_acc <= frame_bad;
          end
          if (cnt == LAST) idx <= idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_cnt_range: assert property (@(posedge clk_i) disable iff (!reset_ni) cnt <= LAST);
  a_state_legal: assert property (@(posedge clk_i) disable iff (!reset_ni)
    state inside {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP});
  a_data_hold: assert property (@(posedge clk_i) disable iff (!reset_ni)
    valid_o && !ready_i |=> $stable(data_o));

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 and a 7E2 instance at 16 clocks per bit,
// a table of frames plus hand-written latency, overrun and reset sequences.
module tb_uart_rx_param;

  typedef struct {
    bit         cfg7;
    logic [7:0] data;
    bit         par_flip;
    bit         stop_zero;
    int         glitch_bit;
    bit         false_start;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic       ready8 = 1'b1;
  logic       ready7 = 1'b1;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, perr8, ferr8, ovr8;
  logic       valid7, perr7, ferr7, ovr7;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   rise8 = 0;
  int   vcnt8 = 0;
  logic prev8 = 1'b0;
  rec_t q8[$];
  rec_t q7[$];

  uart_rx_param #(.DELAY_FRAMES(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx8), .data_o(data8), .valid_o(valid8),
    .ready_i(ready8), .parity_err_o(perr8), .frame_err_o(ferr8), .overrun_o(ovr8)
  );

  uart_rx_param #(.DELAY_FRAMES(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx7), .data_o(data7), .valid_o(valid7),
    .ready_i(ready7), .parity_err_o(perr7), .frame_err_o(ferr7), .overrun_o(ovr7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (valid8 && !prev8) rise8 <= cyc;
    prev8 <= valid8;
    if (valid8) vcnt8 <= vcnt8 + 1;
    if (valid8 && ready8) begin
      r.d = data8; r.pe = perr8; r.fe = ferr8;
      q8.push_back(r);
    end
    if (valid7 && ready7) begin
      r.d = {1'b0, data7}; r.pe = perr7; r.fe = ferr7;
      q7.push_back(r);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cfg7, input logic v);
    if (cfg7) rx7 = v;
    else      rx8 = v;
  endtask

  // Drives one frame at 16 clocks per bit; abort_bits > 0 stops after that many bits
  task automatic send_frame(input bit cfg7, input logic [7:0] d, input bit par_flip,
                            input bit stop_zero, input int glitch_bit, input int abort_bits);
    logic bits [12];
    int   n;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < (cfg7 ? 7 : 8); i++) begin
      bits[n] = d[i];
      n++;
    end
    if (cfg7) begin
      bits[n] = (^d[6:0]) ^ par_flip;
      n++;
    end
    for (int i = 0; i < (cfg7 ? 2 : 1); i++) begin
      bits[n] = ~stop_zero;
      n++;
    end
    if (abort_bits > 0 && abort_bits < n) n = abort_bits;
    fall_cyc = cyc;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 16; k++) begin
        drive(cfg7, (b == glitch_bit && k == 8) ? ~bits[b] : bits[b]);
        tick();
      end
    end
    if (abort_bits == 0) drive(cfg7, 1'b1);
  endtask

  task automatic pop_check(input bit cfg7, input string name, input logic [7:0] d,
                           input bit pe, input bit fe);
    rec_t r;
    if ((cfg7 ? q7.size() : q8.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no word delivered within cycle budget, expected 0x%0h", name, d);
    end else begin
      r = cfg7 ? q7.pop_front() : q8.pop_front();
      chk({name, "_data"}, int'(r.d), int'(d));
      chk({name, "_perr"}, int'(r.pe), int'(pe));
      chk({name, "_ferr"}, int'(r.fe), int'(fe));
    end
  endtask

  vec_t vecs[10];
  int   v0;

  initial begin
    vecs[0] = '{0, 8'h3C, 0, 1, -1, 0, 8'h3C, 0, 1};
    vecs[1] = '{0, 8'h5A, 0, 0, -1, 1, 8'h5A, 0, 0};
    vecs[2] = '{0, 8'hFF, 0, 0,  4, 0, 8'hFF, 0, 0};
    vecs[3] = '{0, 8'h00, 0, 0, -1, 0, 8'h00, 0, 0};
    vecs[4] = '{0, 8'h81, 0, 0, -1, 0, 8'h81, 0, 0};
    vecs[5] = '{1, 8'h41, 0, 0, -1, 0, 8'h41, 0, 0};
    vecs[6] = '{1, 8'h41, 1, 0, -1, 0, 8'h41, 1, 0};
    vecs[7] = '{1, 8'h7F, 0, 0, -1, 0, 8'h7F, 0, 0};
    vecs[8] = '{1, 8'h2A, 0, 1, -1, 0, 8'h2A, 0, 1};
    vecs[9] = '{1, 8'h41, 0, 0,  8, 0, 8'h41, 0, 0};

    repeat (3) tick();
    chk("reset_data8", int'(data8), 0);
    chk("reset_valid8", int'(valid8), 0);
    chk("reset_flags8", int'({perr8, ferr8, ovr8}), 0);
    chk("reset_valid7", int'(valid7), 0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Latency and single-cycle valid with ready held high
    v0 = vcnt8;
    send_frame(0, 8'hA5, 0, 0, -1, 0);
    repeat (40) tick();
    chk("a5_latency", rise8 - fall_cyc, 156);
    chk("a5_valid_cycles", vcnt8 - v0, 1);
    pop_check(0, "a5", 8'hA5, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].false_start) begin
        drive(vecs[i].cfg7, 1'b0);
        repeat (4) tick();
        drive(vecs[i].cfg7, 1'b1);
        repeat (40) tick();
        chk($sformatf("vec%0d_false_start_none", i), q8.size() + q7.size(), 0);
      end
      send_frame(vecs[i].cfg7, vecs[i].data, vecs[i].par_flip, vecs[i].stop_zero,
                 vecs[i].glitch_bit, 0);
      repeat (40) tick();
      pop_check(vecs[i].cfg7, $sformatf("vec%0d", i), vecs[i].exp_data,
                vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    // Overrun: second word dropped while the first is held
    ready8 = 1'b0;
    send_frame(0, 8'h11, 0, 0, -1, 0);
    repeat (20) tick();
    send_frame(0, 8'h22, 0, 0, -1, 0);
    repeat (40) tick();
    chk("ovr_valid_held", int'(valid8), 1);
    chk("ovr_data_held", int'(data8), 'h11);
    chk("ovr_flag_set", int'(ovr8), 1);
    ready8 = 1'b1;
    tick();
    chk("ovr_valid_fell", int'(valid8), 0);
    chk("ovr_flag_cleared", int'(ovr8), 0);
    pop_check(0, "ovr_word", 8'h11, 0, 0);
    repeat (40) tick();
    chk("ovr_no_extra_word", q8.size(), 0);

    // Reset mid-frame while a word is held
    ready8 = 1'b0;
    send_frame(0, 8'h33, 0, 0, -1, 0);
    repeat (40) tick();
    chk("rst_pre_valid", int'(valid8), 1);
    send_frame(0, 8'h77, 0, 0, -1, 4);
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(valid8), 0);
    chk("rst_async_data", int'(data8), 0);
    chk("rst_async_flags", int'({perr8, ferr8, ovr8}), 0);
    drive(0, 1'b1);
    repeat (3) tick();
    reset_n = 1'b1;
    ready8 = 1'b1;
    repeat (40) tick();
    chk("rst_no_spurious", q8.size(), 0);
    send_frame(0, 8'h88, 0, 0, -1, 0);
    repeat (40) tick();
    pop_check(0, "post_rst", 8'h88, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
